// File: rtl/mem_port_unit.sv
// Memory-access stage of the multicycle MIPS core: one bus transaction per access state,
// holding IR/MDR and decoding IR fields. Optional bus timeout enabled by MEM_TIMEOUT_EN.
module mem_port_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] write_data,
  input  logic              i_or_d,
  input  logic              mem_access,
  input  logic              mem_write,
  input  logic              ir_write,
  output logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm,
  output logic [DATA_W-1:0] mdr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              mem_err
);

  localparam logic IDLE = 1'b0;
  localparam logic WAIT = 1'b1;

  logic              state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              ld_ir_q, ld_ir_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              timeout_hit;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign timeout_hit = (state_q == WAIT) && !bus_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Counter sits at zero while idle, so it is clear on entry to WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign mem_err        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    ld_ir_d = ld_ir_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    case (state_q)
      IDLE: begin
        if (mem_access) begin
          state_d = WAIT;
          addr_d  = i_or_d ? alu_out : pc;
          wdata_d = write_data;
          we_d    = mem_write;
          ld_ir_d = ir_write & ~mem_write;
        end
      end
      WAIT: begin
        if (bus_ack) begin
          state_d = IDLE;
          if (!we_q) begin
            mdr_d = bus_rdata;
            if (ld_ir_q) begin
              ir_d = bus_rdata;
            end
          end
        end else if (timeout_hit) begin
          // Aborted fetch leaves an all-zero IR, which decodes as sll $0,$0,0.
          state_d = IDLE;
          if (ld_ir_q) begin
            ir_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ld_ir_q <= 1'b0;
      ir_q    <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ld_ir_q <= ld_ir_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
    end
  end

  assign stall = ((state_q == IDLE) && mem_access) ||
                 ((state_q == WAIT) && !bus_ack && !timeout_hit);

  assign bus_req   = (state_q == WAIT);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  assign instr = ir_q;
  assign mdr   = mdr_q;
  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];
  assign imm   = ir_q[15:0];

endmodule
